// File: rtl/pos_ref_particle_reader.sv
// pos_ref_particle_reader
//   Walks one cell's position memory: reads the particle count from address 0,
//   then issues reads for IDs 1..count under downstream back-pressure. Each
//   returned word is tagged with its ID after exactly RD_LATENCY cycles. The
//   block also produces the neighbour filter of a candidate against the
//   current reference.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, phase      pass request (IDLE only); phase sampled on start
//   rd_en, rd_addr    position RAM read strobe / address
//   rd_count          count field of the RAM word read from address 0
//   ref_ready         downstream can accept reference particles
//   ref_valid, ref_id registered reference particle tag (ID held when idle)
//   particle_id       candidate neighbour ID
//   nb_valid          combinational neighbour filter result
//   ref_count         count latched for this pass
//   busy              high outside IDLE
//   reading_done      one-cycle end-of-pass pulse
module pos_ref_particle_reader #(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int RD_LATENCY        = 1,
  parameter bit HALF_SHELL        = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         phase,
  output logic                         rd_en,
  output logic [PARTICLE_ID_WIDTH-1:0] rd_addr,
  input  logic [PARTICLE_ID_WIDTH-1:0] rd_count,
  input  logic                         ref_ready,
  output logic                         ref_valid,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
  input  logic [PARTICLE_ID_WIDTH-1:0] particle_id,
  output logic                         nb_valid,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_count,
  output logic                         busy,
  output logic                         reading_done
);

  localparam int W = PARTICLE_ID_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ_NUM = 3'd1,
    S_WAIT_NUM = 3'd2,
    S_ISSUE    = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t          state;
  logic            phase_q;
  logic [W:0]      issue_cnt;   // one extra bit so count = 2^W-1 ends cleanly
  logic [2:0]      wait_cnt;
  logic            issue;

  // Return pipeline: valid bits plus IDs; an ID stage only loads when valid
  // data enters it, so the last stage keeps the most recent ID when idle.
  logic [RD_LATENCY-1:0] pipe_v;
  logic [W-1:0]          pipe_id [RD_LATENCY];

  always_comb begin
    issue   = (state == S_ISSUE) && ref_ready;
    rd_en   = (state == S_READ_NUM) || issue;
    rd_addr = issue ? issue_cnt[W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase_q   <= 1'b0;
      issue_cnt <= '0;
      wait_cnt  <= '0;
      ref_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            phase_q <= phase;
            state   <= S_READ_NUM;
          end
        end
        S_READ_NUM: begin
          wait_cnt <= 3'd1;
          state    <= S_WAIT_NUM;
        end
        S_WAIT_NUM: begin
          if (wait_cnt == 3'(RD_LATENCY)) begin
            ref_count <= rd_count;
            issue_cnt <= (W+1)'(1);
            state     <= (rd_count == '0) ? S_DONE : S_ISSUE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        S_ISSUE: begin
          if (ref_ready) begin
            issue_cnt <= issue_cnt + (W+1)'(1);
            if (issue_cnt == {1'b0, ref_count}) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pipe_v == '0) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_id[i] <= '0;
    end else begin
      pipe_v[0] <= issue;
      if (issue) pipe_id[0] <= rd_addr;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  assign ref_valid    = pipe_v[RD_LATENCY-1];
  assign ref_id       = pipe_id[RD_LATENCY-1];
  assign busy         = (state != S_IDLE);
  assign reading_done = (state == S_DONE);

  always_comb begin
    nb_valid = 1'b0;
    if (state == S_ISSUE || state == S_DRAIN || state == S_DONE) begin
      if (phase_q)         nb_valid = 1'b1;
      else if (HALF_SHELL) nb_valid = (particle_id > ref_id);
      else                 nb_valid = (particle_id != ref_id);
    end
  end

endmodule

// File: doc/pos_ref_particle_reader.md
Name: pos_ref_particle_reader

Overview:
- Sequential controller that walks one cell's position memory and emits reference particles with per-particle valid tags.
- Reads the particle count from address 0, then issues reads for IDs 1..count, throttled by downstream ready.
- Tags each returned word with its ref_id and produces the half-shell neighbour filter against the current reference.
- Sits between the cell position RAM and the force pipeline's reference register bank. It replaces the purely combinational valid check with a latency-aware, back-pressured sequencer.

Parameters:
- PARTICLE_ID_WIDTH, 7, width of particle IDs, counts and memory addresses.
- RD_LATENCY, 1, position RAM read latency in cycles; legal range 1..4.
- HALF_SHELL, 1, when 1 the home-cell neighbour filter requires particle_id > ref_id; when 0 it requires particle_id != ref_id.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse that begins a cell pass; ignored unless the block is in IDLE.
- phase  input  1  0 = home-cell neighbours, 1 = neighbour-cell pass (filter forced true); sampled on start.
- rd_en  output  1  RAM read strobe.
- rd_addr  output  PARTICLE_ID_WIDTH  RAM read address.
- rd_count  input  PARTICLE_ID_WIDTH  RAM data field holding the count, valid RD_LATENCY cycles after the address-0 read.
- ref_ready  input  1  downstream can accept reference particles.
- ref_valid  output  1  returned RAM word is a valid reference particle.
- ref_id  output  PARTICLE_ID_WIDTH  ID aligned with ref_valid; holds the last value when ref_valid is low.
- particle_id  input  PARTICLE_ID_WIDTH  candidate neighbour ID from the home-cell stream.
- nb_valid  output  1  combinational: candidate passes the filter against the current ref_id.
- ref_count  output  PARTICLE_ID_WIDTH  count latched for this pass.
- busy  output  1  high in every state except IDLE.
- reading_done  output  1  one-cycle pulse at the end of the pass.

Behaviour:
- Reset values: all outputs 0, state IDLE, in-flight pipeline cleared. An internal phase register resets to 0.
- Reset mid-pass: the block returns to IDLE on the next edge and discards all in-flight reads. No reading_done is produced.
- State IDLE: on start, latch phase and go to READ_NUM.
- State READ_NUM: one cycle with rd_en=1 and rd_addr=0. Go to WAIT_NUM.
- State WAIT_NUM:
  - Wait RD_LATENCY cycles, then latch rd_count into ref_count.
  - If the count is 0, go to DONE. No ref_valid is ever asserted in that pass.
  - Otherwise set the issue counter to 1 and go to ISSUE.
  - No ref_valid is asserted while reading the count.
- State ISSUE:
  - Each cycle with ref_ready=1, drive rd_en=1 and rd_addr=issue counter, then increment the counter.
  - When ref_ready=0, drive rd_en=0 and hold the counter.
  - After issuing addr == ref_count, go to DRAIN.
  - The issue counter is PARTICLE_ID_WIDTH+1 bits wide, so count = 2^W-1 terminates without wrap.
- State DRAIN: wait until the valid shift register is empty, then go to DONE.
- State DONE: reading_done=1 for exactly one cycle, then go to IDLE.
  - A start pulse arriving in the DONE cycle is ignored.
- Return pipeline:
  - A shift register of depth RD_LATENCY carries {valid, id} for each issued read.
  - ref_valid and ref_id are registered outputs, asserted exactly RD_LATENCY cycles after the matching rd_en.
  - Back-pressure skid: after ref_ready falls, up to RD_LATENCY already-issued particles still emerge. Downstream must absorb them.
- nb_valid:
  - phase=1: nb_valid = 1.
  - phase=0 and HALF_SHELL=1: nb_valid = (particle_id > ref_id).
  - phase=0 and HALF_SHELL=0: nb_valid = (particle_id != ref_id).
  - nb_valid is forced to 0 in IDLE, READ_NUM and WAIT_NUM.
- start while busy: ignored, with no effect on the pass in progress.

Test Plan:
- Count=3, RD_LATENCY=1, ref_ready held 1: rd_addr sequence 0,1,2,3. ref_valid is high 3 consecutive cycles with ref_id 1,2,3. reading_done pulses 1 cycle after the last ref_valid clears DRAIN.
- Count=0: exactly one rd_en (addr 0), zero ref_valid, reading_done 1 pulse; the total pass from start pulse takes RD_LATENCY+3 cycles.
- Count=5, RD_LATENCY=2, ref_ready low for 3 cycles after the 2nd issue: 2 in-flight refs still emerge. Issue resumes at addr 3, the ref_id sequence 1..5 has no gaps or duplicates, and exactly 5 ref_valid are produced.
- phase=0, HALF_SHELL=1, ref_id=4: particle_id 3 -> nb_valid 0, 4 -> 0, 5 -> 1. phase=1 gives nb_valid 1 for all three.
- Count=127, PARTICLE_ID_WIDTH=7: last rd_addr=127, 127 ref_valid produced, the pass terminates with reading_done and busy returns to 0.
- rst asserted during ISSUE at ref_id 2 of 6: the next cycle shows busy=0 and ref_valid=0 with no reading_done. A subsequent start runs a clean pass from addr 0.
